// File: rtl/prio_arbiter_rr_hold.sv
// rtl/prio_arbiter_rr_hold.sv - registered fixed-priority / round-robin arbiter with bounded grant hold
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req        request vector, bit i = requester i wants the resource
//   hold       current grantee keeps the grant while its request stays high
//   gnt        registered one-hot grant, zero when idle
//   gnt_valid  registered, equals |gnt
//   gnt_id     registered binary index of the set gnt bit, zero when idle
//
// Parameters:
//   SIZE      number of requesters (2..64)
//   MODE      0 = fixed priority (MSB highest), 1 = round-robin
//   MAX_HOLD  maximum consecutive cycles of one held grant, 0 = unlimited

module prio_arbiter_rr_hold #(
    parameter int SIZE     = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SIZE-1:0]           req,
    input  logic                      hold,
    output logic [SIZE-1:0]           gnt,
    output logic                      gnt_valid,
    output logic [$clog2(SIZE)-1:0]   gnt_id
);

    localparam int IW = $clog2(SIZE);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    // Pointer reset value: with ptr at the top index the first round-robin
    // decision matches the fixed-priority result.
    localparam logic [IW-1:0] PTR_RST = IW'(SIZE - 1);

    // Last hold_cnt value before the grant expires. With unlimited hold the
    // counter only needs to saturate, so all-ones doubles as the cap.
    localparam logic [HW-1:0] CNT_LAST = (MAX_HOLD == 0) ? '1 : HW'(MAX_HOLD - 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;

    logic             holding;
    logic             keep;
    logic             expire;
    logic [SIZE-1:0]  others;
    logic [SIZE-1:0]  cand;
    logic [SIZE-1:0]  low_mask;
    logic [SIZE-1:0]  cand_low;
    logic [IW-1:0]    win;
    logic [SIZE-1:0]  win_oh;

    // Index of the highest set bit; zero for an empty vector.
    function automatic logic [IW-1:0] msb_index(input logic [SIZE-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    // Grantee still asking and hold requested; decide whether it may keep
    // the grant or has used up its allowance.
    assign holding = (state == S_GRANTED) && req[gnt_id] && hold;
    assign keep    = holding && ((MAX_HOLD == 0) || (hold_cnt < CNT_LAST));
    assign expire  = holding && !keep;

    // On expiry the holder steps aside only if someone else is waiting;
    // a lone holder is simply re-granted.
    assign others = req & ~gnt;
    assign cand   = (expire && (others != '0)) ? others : req;

    // Round-robin search order ptr, ptr-1, ..., 0, SIZE-1, ..., ptr+1 is the
    // highest candidate at or below ptr, otherwise the highest candidate
    // overall (which then necessarily lies above ptr).
    always_comb begin
        low_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            low_mask[i] = (i <= int'(ptr));
        end
    end

    assign cand_low = cand & low_mask;

    always_comb begin
        win = '0;
        if (MODE == 0) begin
            win = msb_index(cand);
        end else if (cand_low != '0) begin
            win = msb_index(cand_low);
        end else begin
            win = msb_index(cand);
        end
    end

    assign win_oh = SIZE'(1) << win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            ptr       <= PTR_RST;
            hold_cnt  <= '0;
        end else if (keep) begin
            // Grant, id and pointer stay put; only the hold counter advances.
            hold_cnt <= (hold_cnt == CNT_LAST) ? hold_cnt : hold_cnt + HW'(1);
        end else if (cand != '0) begin
            state     <= S_GRANTED;
            gnt       <= win_oh;
            gnt_valid <= 1'b1;
            gnt_id    <= win;
            hold_cnt  <= '0;
            // The winner drops to lowest priority for the next decision.
            if (MODE != 0) begin
                ptr <= (win == '0) ? PTR_RST : win - IW'(1);
            end
        end else begin
            state     <= S_IDLE;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            hold_cnt  <= '0;
        end
    end

endmodule

// File: tb/tb_prio_arbiter_rr_hold.sv
// tb/tb_prio_arbiter_rr_hold.sv - scoreboard bench for prio_arbiter_rr_hold

module tb_prio_arbiter_rr_hold;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       hold = 1'b0;

    logic [3:0] gnt_a   [4];
    logic       valid_a [4];
    logic [1:0] id_a    [4];

    always #5 clk = ~clk;

    // 0: round-robin, unlimited hold
    prio_arbiter_rr_hold #(.SIZE(4), .MODE(1), .MAX_HOLD(0)) u_rr (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .gnt(gnt_a[0]), .gnt_valid(valid_a[0]), .gnt_id(id_a[0]));

    // 1: fixed priority
    prio_arbiter_rr_hold #(.SIZE(4), .MODE(0), .MAX_HOLD(0)) u_fp (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .gnt(gnt_a[1]), .gnt_valid(valid_a[1]), .gnt_id(id_a[1]));

    // 2: round-robin, hold limit 3
    prio_arbiter_rr_hold #(.SIZE(4), .MODE(1), .MAX_HOLD(3)) u_bh (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .gnt(gnt_a[2]), .gnt_valid(valid_a[2]), .gnt_id(id_a[2]));

    // 3: round-robin, hold limit 2
    prio_arbiter_rr_hold #(.SIZE(4), .MODE(1), .MAX_HOLD(2)) u_lh (
        .clk(clk), .rst(rst), .req(req), .hold(hold),
        .gnt(gnt_a[3]), .gnt_valid(valid_a[3]), .gnt_id(id_a[3]));

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] gnt;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    event chk_ev;

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic void check_entry(input exp_t e);
        logic [3:0] ag;
        logic       av;
        logic [1:0] ai;
        ag = gnt_a[e.dut];
        av = valid_a[e.dut];
        ai = id_a[e.dut];
        tests_run += 3;
        if (ag !== e.gnt) begin
            tests_failed++;
            $display("FAIL %s gnt: got %b expected %b", e.name, ag, e.gnt);
        end
        if (av !== (|e.gnt)) begin
            tests_failed++;
            $display("FAIL %s gnt_valid: got %b expected %b", e.name, av, |e.gnt);
        end
        if (ai !== enc(e.gnt)) begin
            tests_failed++;
            $display("FAIL %s gnt_id: got %0d expected %0d", e.name, ai, enc(e.gnt));
        end
    endfunction

    // Edge monitor: outputs sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc != -1 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s missed: due cycle %0d now %0d", e.name, e.cyc, cyc);
            end else begin
                check_entry(e);
            end
        end
    end

    // Immediate monitor for checks between edges (asynchronous reset).
    always begin
        exp_t e;
        @(chk_ev);
        while (sb.size() > 0 && sb[0].cyc == -1) begin
            e = sb.pop_front();
            check_entry(e);
        end
    end

    task automatic step(input logic [3:0] r, input logic h, input int d,
                        input logic [3:0] eg, input string nm);
        req  = r;
        hold = h;
        sb.push_back('{cyc + 1, d, eg, nm});
        @(negedge clk);
    endtask

    task automatic imm_check(input int d, input logic [3:0] eg, input string nm);
        sb.push_back('{-1, d, eg, nm});
        ->chk_ev;
        #1;
    endtask

    task automatic do_reset();
        req  = 4'b0000;
        hold = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    initial begin
        // Reset and first grant
        #1 rst = 1'b1;
        #2 imm_check(0, 4'b0000, "reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(4'b1010, 1'b0, 0, 4'b1000, "first_grant");

        // Round-robin rotation
        do_reset();
        step(4'b1111, 1'b0, 0, 4'b1000, "rot0");
        step(4'b1111, 1'b0, 0, 4'b0100, "rot1");
        step(4'b1111, 1'b0, 0, 4'b0010, "rot2");
        step(4'b1111, 1'b0, 0, 4'b0001, "rot3");
        step(4'b1111, 1'b0, 0, 4'b1000, "rot4");
        step(4'b0101, 1'b0, 0, 4'b0100, "rot5");
        step(4'b0101, 1'b0, 0, 4'b0001, "rot6");
        step(4'b0101, 1'b0, 0, 4'b0100, "rot7");
        // Unlimited hold keeps the grant
        step(4'b1111, 1'b1, 0, 4'b0100, "hold_inf0");
        step(4'b1111, 1'b1, 0, 4'b0100, "hold_inf1");
        step(4'b1111, 1'b1, 0, 4'b0100, "hold_inf2");
        step(4'b0000, 1'b1, 0, 4'b0000, "rr_idle");

        // Fixed priority
        do_reset();
        step(4'b1111, 1'b0, 1, 4'b1000, "fp0");
        step(4'b1111, 1'b0, 1, 4'b1000, "fp1");
        step(4'b1111, 1'b0, 1, 4'b1000, "fp2");
        step(4'b0110, 1'b0, 1, 4'b0100, "fp3");
        step(4'b0011, 1'b0, 1, 4'b0010, "fp4");
        step(4'b0000, 1'b0, 1, 4'b0000, "fp_idle");

        // Bounded hold, MAX_HOLD=3
        do_reset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                step(4'b1111, 1'b1, 2, 4'b1000 >> k, $sformatf("bh_%0d_%0d", k, j));
            end
        end
        step(4'b1111, 1'b1, 2, 4'b1000, "bh_wrap");

        // Lone holder and drop, MAX_HOLD=2
        do_reset();
        for (int j = 0; j < 5; j++) begin
            step(4'b0001, 1'b1, 3, 4'b0001, $sformatf("lone_%0d", j));
        end
        step(4'b0100, 1'b1, 3, 4'b0100, "drop");

        // Asynchronous reset mid-hold
        do_reset();
        step(4'b0011, 1'b0, 0, 4'b0010, "pre_hold");
        step(4'b0011, 1'b1, 0, 4'b0010, "in_hold");
        rst = 1'b1;
        #2 imm_check(0, 4'b0000, "async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(4'b0011, 1'b1, 0, 4'b0010, "after_rst");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
